imem_dmem_arbiter: RTL and testbench

- Shares one single-port instruction/data memory between the instruction-fetch port and the load/store port of the RISC-V core.
- Sits between RISC_V_TOP's fetch/LSU interfaces and the memory macro; the memory macro replaces the separate inst_rom.
- Enforces one outstanding read, fixed read latency, data-port priority with fetch anti-starvation.
- Drives a stall indication back to the pipeline.

---
 rtl/imem_dmem_arbiter_pkg.sv | 36 +++
 rtl/imem_dmem_arbiter_arb_prio2.sv | 42 ++++
 rtl/imem_dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: reset level,
// owner and state encodings, bus widths and the wait-counter helper.
package imem_dmem_arbiter_pkg;

  // Reset is active-high
  localparam logic RstEnable = 1'b1;

  // Which port owns the read that is currently in flight
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  // Bus widths shared with the core
  localparam int RegBus = 32;
  localparam int SelBus = 4;

  // Fetches always read the full word
  localparam logic [SelBus-1:0] SEL_WORD = 4'hF;

  // Wide enough for MAX_WAIT up to 15
  localparam int WaitW = 4;

  // Wide enough for RD_LAT-1 with RD_LAT up to 4
  localparam int LatW = 2;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } arb_state_t;

  // Saturating increment used by the fetch anti-starvation counter
  function automatic logic [WaitW-1:0] sat_inc(input logic [WaitW-1:0] cur,
                                               input logic [WaitW-1:0] lim);
    return (cur >= lim) ? lim : cur + {{(WaitW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_arb_prio2.sv
// Two-input grant selector for the fetch (if) and load/store (ls) ports.
// Build option ARB_RR_EN: when defined, conflicts go to the port that did
// not win last time; otherwise ls wins unless the fetch is being forced.
module arb_prio2
  import imem_dmem_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic ls_req,
  input  logic force_if,
  input  logic last_ls,
  output logic if_win,
  output logic ls_win
);

  logic prefer_if;
  logic unused_flag;

`ifdef ARB_RR_EN
  assign prefer_if   = last_ls;
  assign unused_flag = force_if;
`else
  assign prefer_if   = force_if;
  assign unused_flag = last_ls;
`endif

  // One-hot winner: a lone request wins outright, a conflict follows prefer_if
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (if_req && ls_req) begin
      if (prefer_if) begin
        if_win = 1'b1;
      end else begin
        ls_win = 1'b1;
      end
    end else begin
      if_win = if_req;
      ls_win = ls_req;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One read may be outstanding; read data returns RD_LAT cycles after the
// grant and is passed straight through to the owning port. Grants are
// combinational so a port is served in the cycle it asks if the memory is
// free. Build option ARB_RR_EN selects strict round-robin instead of
// ls-priority with the MAX_WAIT fetch anti-starvation counter.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = RegBus,
  parameter int DATA_W   = RegBus,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [SelBus-1:0] ls_sel_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [SelBus-1:0] mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  arb_state_t      state;
  logic [LatW-1:0] lat_cnt;
  logic            owner;
  logic            last_ls;
  logic            force_if;
  logic            if_win;
  logic            ls_win;
  logic            can_arb;
  logic            resp_now;
  logic            read_gnt;
  logic            not_reset;

  // Everything visible is held low while reset is asserted
  assign not_reset = (rst != RstEnable);

  // Arbitration happens when idle, or in the cycle the pending read returns
  assign can_arb  = not_reset && ((state == S_IDLE) || (lat_cnt == '0));
  assign resp_now = not_reset && (state == S_RD_WAIT) && (lat_cnt == '0);

  arb_prio2 u_arb (
    .if_req   (if_req_i),
    .ls_req   (ls_req_i),
    .force_if (force_if),
    .last_ls  (last_ls),
    .if_win   (if_win),
    .ls_win   (ls_win)
  );

  assign if_gnt_o = can_arb && if_win;
  assign ls_gnt_o = can_arb && ls_win;
  assign read_gnt = if_gnt_o || (ls_gnt_o && !ls_we_i);
  assign stall_o  = not_reset && if_req_i && !if_gnt_o;

  // Read sequencing: a granted read waits RD_LAT cycles, stores never leave IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      owner   <= OWN_IF;
    end else if (read_gnt) begin
      state   <= S_RD_WAIT;
      lat_cnt <= LatW'(RD_LAT - 1);
      owner   <= ls_gnt_o ? OWN_LS : OWN_IF;
    end else if (can_arb) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
    end else begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

`ifdef ARB_RR_EN
  assign force_if = 1'b0;

  // Remember who won last so a conflict goes to the other port
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      last_ls <= OWN_LS;
    end else if (if_gnt_o || ls_gnt_o) begin
      last_ls <= ls_gnt_o;
    end
  end
`else
  logic [WaitW-1:0] wait_cnt;

  assign last_ls  = OWN_LS;
  assign force_if = (wait_cnt == WaitW'(MAX_WAIT));

  // Count consecutive cycles a fetch has been refused; at MAX_WAIT it wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wait_cnt <= '0;
    end else if (if_req_i && !if_gnt_o) begin
      wait_cnt <= sat_inc(wait_cnt, WaitW'(MAX_WAIT));
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

  // Memory request mux: the winner's request goes to the macro this cycle
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_sel_o   = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (ls_gnt_o) begin
      mem_ce_o    = 1'b1;
      mem_we_o    = ls_we_i;
      mem_sel_o   = ls_sel_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
    end else if (if_gnt_o) begin
      mem_ce_o   = 1'b1;
      mem_sel_o  = SEL_WORD;
      mem_addr_o = if_addr_i;
    end
  end

  // Response steering: read data goes only to the owner, zero otherwise
  always_comb begin
    if_rvalid_o = resp_now && (owner == OWN_IF);
    ls_rvalid_o = resp_now && (owner == OWN_LS);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter: directed scenarios followed by random
// traffic. A cycle-level reference model predicts grants and memory
// accesses; predicted read responses are queued and a monitor process
// checks them when the DUT returns data.
module tb_imem_dmem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt_o, if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              ls_req = 1'b0;
  logic              ls_we = 1'b0;
  logic [3:0]        ls_sel = 4'hF;
  logic [ADDR_W-1:0] ls_addr = '0;
  logic [DATA_W-1:0] ls_wdata = '0;
  logic              ls_gnt_o, ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;
  logic              mem_ce_o, mem_we_o;
  logic [3:0]        mem_sel_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_sel_i(ls_sel),
    .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
  );

  function automatic logic [31:0] initWord(input int i);
    return (i == 4) ? 32'h0050_0093 : (32'h1357_9BDF ^ (32'(i) * 32'h0101_0101));
  endfunction

  function automatic logic [31:0] randAddr();
    return ($urandom() & 32'hFFFF_FFC0) | (32'($urandom_range(15)) << 2);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory macro stand-in, driven only by the DUT's mem_* outputs
  logic [31:0] emul_mem [16];
  logic [31:0] rd_pipe [RD_LAT];
  logic        acc_rd = 1'b0, acc_wr = 1'b0;
  logic [3:0]  acc_idx = '0, acc_sel = '0;
  logic [31:0] acc_wdata = '0;

  assign mem_rdata_i = rd_pipe[RD_LAT-1];

  always @(negedge clk) begin
    acc_rd    = mem_ce_o && !mem_we_o;
    acc_wr    = mem_ce_o && mem_we_o;
    acc_idx   = mem_addr_o[5:2];
    acc_sel   = mem_sel_o;
    acc_wdata = mem_wdata_o;
  end

  always @(posedge clk) begin
    for (int k = RD_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    rd_pipe[0] <= acc_rd ? emul_mem[acc_idx] : ($urandom() | 32'h1);
    if (acc_wr)
      for (int b = 0; b < 4; b++)
        if (acc_sel[b]) emul_mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
  end

  // Handshake view for the stimulus: was the current request granted?
  logic if_gnt_seen = 1'b0, ls_gnt_seen = 1'b0;
  always @(negedge clk) begin
    if_gnt_seen = if_gnt_o;
    ls_gnt_seen = ls_gnt_o;
  end

  // Reference model: memory is free again RD_LAT cycles after a read grant
  typedef struct {
    int          due;
    bit          is_ls;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [16];
  int          free_cyc = 0;
  int          m_wait = 0;
  bit          m_last_ls = 1'b1;
  bit          e_if, e_ls;
  logic [31:0] merged;

  always @(negedge clk) begin
    e_if = 1'b0;
    e_ls = 1'b0;
    if (rst) begin
      exp_q.delete();
      free_cyc  = 0;
      m_wait    = 0;
      m_last_ls = 1'b1;
    end else begin
      if (cyc >= free_cyc) begin
        if (if_req && ls_req) begin
`ifdef ARB_RR_EN
          if (m_last_ls) e_if = 1'b1; else e_ls = 1'b1;
`else
          if (m_wait >= MAX_WAIT) e_if = 1'b1; else e_ls = 1'b1;
`endif
        end else begin
          e_if = if_req;
          e_ls = ls_req;
        end
      end
      if (e_if) begin
        exp_q.push_back('{due: cyc + RD_LAT, is_ls: 1'b0, data: ref_mem[if_addr[5:2]]});
        free_cyc = cyc + RD_LAT;
      end
      if (e_ls && ls_we) begin
        merged = ref_mem[ls_addr[5:2]];
        for (int b = 0; b < 4; b++)
          if (ls_sel[b]) merged[8*b +: 8] = ls_wdata[8*b +: 8];
        ref_mem[ls_addr[5:2]] = merged;
      end else if (e_ls) begin
        exp_q.push_back('{due: cyc + RD_LAT, is_ls: 1'b1, data: ref_mem[ls_addr[5:2]]});
        free_cyc = cyc + RD_LAT;
      end
      if (e_if || e_ls) m_last_ls = e_ls;
      if (if_req && !e_if) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else m_wait = 0;
    end
    checkOutput("if_gnt", 32'(if_gnt_o), 32'(e_if));
    checkOutput("ls_gnt", 32'(ls_gnt_o), 32'(e_ls));
    checkOutput("stall", 32'(stall_o), 32'(!rst && if_req && !e_if));
    checkOutput("mem_ce", 32'(mem_ce_o), 32'(e_if || e_ls));
    if (e_ls) begin
      checkOutput("mem_we_ls", 32'(mem_we_o), 32'(ls_we));
      checkOutput("mem_addr_ls", mem_addr_o, ls_addr);
      checkOutput("mem_sel_ls", 32'(mem_sel_o), 32'(ls_sel));
      if (ls_we) checkOutput("mem_wdata", mem_wdata_o, ls_wdata);
    end else if (e_if) begin
      checkOutput("mem_we_if", 32'(mem_we_o), 32'd0);
      checkOutput("mem_addr_if", mem_addr_o, if_addr);
      checkOutput("mem_sel_if", 32'(mem_sel_o), 32'hF);
    end
  end

  // Monitor: compares returned read data against the queued predictions
  exp_t mon_e;
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      checkOutput("if_rvalid", 32'(if_rvalid_o), 32'(!mon_e.is_ls));
      checkOutput("ls_rvalid", 32'(ls_rvalid_o), 32'(mon_e.is_ls));
      checkOutput(mon_e.is_ls ? "ls_rdata" : "if_rdata",
                  mon_e.is_ls ? ls_rdata_o : if_rdata_o, mon_e.data);
      checkOutput("other_rdata_zero", mon_e.is_ls ? if_rdata_o : ls_rdata_o, 32'd0);
    end else begin
      checkOutput("if_rvalid_quiet", 32'(if_rvalid_o), 32'd0);
      checkOutput("ls_rvalid_quiet", 32'(ls_rvalid_o), 32'd0);
      checkOutput("if_rdata_quiet", if_rdata_o, 32'd0);
      checkOutput("ls_rdata_quiet", ls_rdata_o, 32'd0);
    end
  end

  // One cycle of random traffic that keeps each request until it is granted
  task automatic applyStimulus(input int p_if, input int p_ls);
    @(posedge clk); #1;
    if (if_gnt_seen) if_req = 1'b0;
    if (ls_gnt_seen) ls_req = 1'b0;
    if (!if_req && int'($urandom_range(99)) < p_if) begin
      if_req  = 1'b1;
      if_addr = randAddr();
    end
    if (!ls_req && int'($urandom_range(99)) < p_ls) begin
      ls_req   = 1'b1;
      ls_we    = ($urandom_range(2) == 0);
      ls_sel   = 4'($urandom_range(1, 15));
      ls_addr  = randAddr();
      ls_wdata = $urandom();
    end
  endtask

  task automatic waitGnt(input bit is_ls, input string name, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(is_ls ? ls_gnt_seen : if_gnt_seen) && n < 64);
    if (!(is_ls ? ls_gnt_seen : if_gnt_seen))
      checkOutput({name, "_timeout"}, 32'(n), 32'd0);
    if (is_ls) ls_req = 1'b0; else if_req = 1'b0;
  endtask

  task automatic idle(input int n);
    if_req = 1'b0;
    ls_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  int n_cyc;
  int ls_before;
  int starve_budget;

  initial begin
    for (int i = 0; i < 16; i++) begin
      emul_mem[i] = initWord(i);
      ref_mem[i]  = initWord(i);
    end
    for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = '0;

    // Requests present during reset must not be granted
    if_req  = 1'b1;
    ls_req  = 1'b1;
    if_addr = 32'h0000_0010;
    ls_addr = 32'h0000_0020;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    if_req = 1'b0;
    ls_req = 1'b0;
    idle(2);

    $display("[TB] single fetch");
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    waitGnt(1'b0, "single_fetch", n_cyc);
    checkOutput("single_fetch_latency", 32'(n_cyc), 32'd1);
    idle(RD_LAT + 2);

    $display("[TB] simultaneous fetch and load");
    if_req  = 1'b1;
    if_addr = 32'h0000_0024;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_sel  = 4'hF;
    ls_addr = 32'h0000_0020;
    waitGnt(1'b1, "simul_ls", n_cyc);
    waitGnt(1'b0, "simul_if", n_cyc);
    checkOutput("simul_if_after_ls", 32'(n_cyc), 32'(RD_LAT));
    idle(RD_LAT + 2);

    $display("[TB] store then load");
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_sel   = 4'b0011;
    ls_addr  = 32'h0000_0030;
    ls_wdata = 32'hDEAD_BEEF;
    waitGnt(1'b1, "store", n_cyc);
    ls_req = 1'b1;
    ls_we  = 1'b0;
    ls_sel = 4'hF;
    waitGnt(1'b1, "load_after_store", n_cyc);
    checkOutput("load_after_store_latency", 32'(n_cyc), 32'd1);
    idle(RD_LAT + 2);

    $display("[TB] fetch starvation");
    ls_before     = 0;
    starve_budget = 0;
    if_req        = 1'b1;
    if_addr       = randAddr();
    do begin
      applyStimulus(0, 100);
      if (ls_gnt_seen) ls_before++;
      starve_budget++;
    end while (!if_gnt_seen && starve_budget < 200);
    if_req = 1'b0;
    checkOutput("starve_if_granted", 32'(if_gnt_seen), 32'd1);
    checkOutput("starve_ls_wins_bounded", 32'(ls_before <= MAX_WAIT), 32'd1);
    idle(RD_LAT + 2);

    $display("[TB] reset during read");
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_sel  = 4'hF;
    ls_addr = 32'h0000_0008;
    waitGnt(1'b1, "rst_load", n_cyc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_000C;
    waitGnt(1'b0, "fetch_after_rst", n_cyc);
    checkOutput("fetch_after_rst_latency", 32'(n_cyc), 32'd1);
    idle(RD_LAT + 2);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(40, 50);
      if ($urandom_range(249) == 0) begin
        @(posedge clk); #1;
        rst    = 1'b1;
        if_req = 1'b0;
        ls_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end
    idle(RD_LAT + 4);
    checkOutput("responses_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
